// File: rtl/pmem_responder.sv
// pmem_responder: line-granular memory endpoint for the pmem_* interface.
// It serves one 256-bit read or write at a time. Each transaction completes
// LATENCY cycles after acceptance with a one-cycle pmem_resp pulse.
// Faulted requests raise pmem_error alongside resp and leave the array alone.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for pmem_read/pmem_write; accepts on the next edge
// BUSY    | latency countdown; resp is driven while the counter is zero
// RECOVER | one turnaround cycle, requests ignored, then back to IDLE
module pmem_responder #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic         pmem_error,
  output logic [255:0] pmem_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [26:0] DEPTH_LINES = 27'(DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic           err_q, err_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   mem_q [DEPTH];

  logic           in_range;
  logic           resp_cycle;
  logic           mem_we;

  // Byte offset within a line carries no information for this endpoint.
  logic           unused_addr_bits;
  assign unused_addr_bits = ^pmem_address[4:0];

  assign in_range   = (pmem_address[31:5] < DEPTH_LINES);
  assign resp_cycle = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we     = resp_cycle && wr_q && !err_q;

  // Responses depend only on latched transaction state, never on live inputs.
  assign pmem_resp  = resp_cycle;
  assign pmem_error = resp_cycle && err_q;
  assign pmem_rdata = (resp_cycle && rd_q && !wr_q && !err_q) ? mem_q[idx_q] : '0;

  // Next-state logic: capture the request at acceptance, count down the latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          rd_d    = pmem_read;
          wr_d    = pmem_write;
          idx_d   = pmem_address[5 +: AW];
          wdata_d = pmem_wdata;
          err_d   = !in_range || (pmem_read && pmem_write);
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Line storage: cleared on reset, written on the edge that ends the resp cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: two instances (LATENCY 4 and 1) share clock and
// reset. A transaction-level model predicts resp/error/rdata each cycle, and
// directed scenarios pin the model with literal expectations.
module tb_pmem_responder;

  localparam int DEPTH = 16;
  localparam int LAT0  = 4;
  localparam int LAT1  = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_i    [2];
  logic         wr_i    [2];
  logic [31:0]  addr_i  [2];
  logic [255:0] wdata_i [2];
  logic         resp_o  [2];
  logic         err_o   [2];
  logic [255:0] rdata_o [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst),
    .pmem_read(rd_i[0]), .pmem_write(wr_i[0]),
    .pmem_address(addr_i[0]), .pmem_wdata(wdata_i[0]),
    .pmem_resp(resp_o[0]), .pmem_error(err_o[0]), .pmem_rdata(rdata_o[0])
  );

  pmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst),
    .pmem_read(rd_i[1]), .pmem_write(wr_i[1]),
    .pmem_address(addr_i[1]), .pmem_wdata(wdata_i[1]),
    .pmem_resp(resp_o[1]), .pmem_error(err_o[1]), .pmem_rdata(rdata_o[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Model state: memory image plus at most one pending transaction per instance,
  // timestamped in clock edges.
  logic [255:0] mmem   [2][DEPTH];
  bit           pv     [2];
  int           p_resp [2];
  int           free_at[2];
  logic         p_rd   [2];
  logic         p_wr   [2];
  logic         p_err  [2];
  int           p_idx  [2];
  logic [255:0] p_wd   [2];
  int           cyc = 0;

  initial begin
    int ln;
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0; free_at[k] = 0;
      for (int i = 0; i < DEPTH; i++) mmem[k][i] = '0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          pv[k] = 1'b0; free_at[k] = 0;
          for (int i = 0; i < DEPTH; i++) mmem[k][i] = '0;
        end
      end else begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
          if (pv[k] && cyc == p_resp[k] + 1) begin
            if (p_wr[k] && !p_err[k]) mmem[k][p_idx[k]] = p_wd[k];
            pv[k] = 1'b0;
          end
          if (!pv[k] && cyc >= free_at[k] && (rd_i[k] || wr_i[k])) begin
            ln         = int'(addr_i[k][31:5]);
            pv[k]      = 1'b1;
            p_resp[k]  = cyc + lat_of(k) - 1;
            free_at[k] = cyc + lat_of(k) + 2;
            p_rd[k]    = rd_i[k];
            p_wr[k]    = wr_i[k];
            p_err[k]   = (ln >= DEPTH) || (rd_i[k] && wr_i[k]);
            p_idx[k]   = ln % DEPTH;
            p_wd[k]    = wdata_i[k];
          end
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  initial begin
    logic         er, ee;
    logic [255:0] ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          er = pv[k] && (cyc == p_resp[k]);
          ee = er && p_err[k];
          ed = (er && p_rd[k] && !p_wr[k] && !p_err[k]) ? mmem[k][p_idx[k]] : '0;
          vectors++;
          if (resp_o[k] !== er || err_o[k] !== ee || rdata_o[k] !== ed) begin
            miscompares++;
            $display("FAIL cycle_check inst%0d cyc%0d: got resp=%b err=%b rdata=%h, need resp=%b err=%b rdata=%h",
                     k, cyc, resp_o[k], err_o[k], rdata_o[k], er, ee, ed);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h", nm, got, exp);
    end
  endtask

  // Drives one request from a negedge in IDLE; mode 1 changes address/data
  // after acceptance, mode 2 drops the request after acceptance.
  task automatic txn_mid(input int k, input logic r, input logic w,
                         input logic [31:0] a, input logic [255:0] d,
                         input int mode, input logic [31:0] a2, input logic [255:0] d2,
                         output int lat, output logic [255:0] rdo, output logic eo);
    rd_i[k] = r; wr_i[k] = w; addr_i[k] = a; wdata_i[k] = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && mode == 1) begin addr_i[k] = a2; wdata_i[k] = d2; end
      if (lat == 1 && mode == 2) begin rd_i[k] = 1'b0; wr_i[k] = 1'b0; end
    end while (!resp_o[k] && lat < 30);
    if (!resp_o[k]) begin
      miscompares++;
      $display("FAIL resp_timeout inst%0d: got no resp in %0d cycles, need one", k, lat);
    end
    rdo = rdata_o[k];
    eo  = err_o[k];
    rd_i[k] = 1'b0; wr_i[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic txn(input int k, input logic r, input logic w,
                     input logic [31:0] a, input logic [255:0] d,
                     output int lat, output logic [255:0] rdo, output logic eo);
    txn_mid(k, r, w, a, d, 0, 32'h0, '0, lat, rdo, eo);
  endtask

  initial begin
    int           lat, first, second, nresp;
    logic [255:0] rd;
    logic         e;
    logic [255:0] beef, pat_a, pat_b;
    beef  = {8{32'hDEADBEEF}};
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'h5A5A_0002}};
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rd_i[k] = 1'b0; wr_i[k] = 1'b0; addr_i[k] = '0; wdata_i[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_resp", {255'd0, resp_o[0]}, '0);
    check("reset_error", {255'd0, err_o[0]}, '0);
    check("reset_rdata", rdata_o[0], '0);
    #2 rst = 1'b0;
    @(negedge clk);

    txn(0, 1'b1, 1'b0, 32'h40, '0, lat, rd, e);
    check("read40_latency", 256'(lat), 256'(4));
    check("read40_rdata", rd, '0);
    check("read40_error", {255'd0, e}, '0);

    txn(0, 1'b0, 1'b1, 32'h60, beef, lat, rd, e);
    check("write60_latency", 256'(lat), 256'(4));
    check("write60_error", {255'd0, e}, '0);
    txn(0, 1'b1, 1'b0, 32'h60, '0, lat, rd, e);
    check("read60_rdata", rd, beef);
    txn(0, 1'b1, 1'b0, 32'h7F, '0, lat, rd, e);
    check("read7F_rdata", rd, beef);

    txn(0, 1'b0, 1'b1, 32'h200, {8{32'hFFFF_FFFF}}, lat, rd, e);
    check("write200_error", {255'd0, e}, 256'd1);
    txn(0, 1'b1, 1'b0, 32'h000, '0, lat, rd, e);
    check("read000_noalias", rd, '0);
    txn(0, 1'b1, 1'b0, 32'h200, '0, lat, rd, e);
    check("read200_error", {255'd0, e}, 256'd1);
    check("read200_rdata", rd, '0);

    txn(0, 1'b1, 1'b1, 32'h60, {8{32'h1234_5678}}, lat, rd, e);
    check("both_error", {255'd0, e}, 256'd1);
    txn(0, 1'b1, 1'b0, 32'h60, '0, lat, rd, e);
    check("both_nochange", rd, beef);

    txn_mid(0, 1'b0, 1'b1, 32'h80, pat_a, 1, 32'hA0, pat_b, lat, rd, e);
    txn(0, 1'b1, 1'b0, 32'h80, '0, lat, rd, e);
    check("latched_addr_data", rd, pat_a);
    txn(0, 1'b1, 1'b0, 32'hA0, '0, lat, rd, e);
    check("changed_addr_untouched", rd, '0);

    txn_mid(0, 1'b1, 1'b0, 32'h80, '0, 2, 32'h0, '0, lat, rd, e);
    check("dropped_latency", 256'(lat), 256'(4));
    check("dropped_rdata", rd, pat_a);

    // Held request: second acceptance LATENCY+2 after the first.
    rd_i[0] = 1'b1; addr_i[0] = 32'h60;
    first = -1; second = -1;
    for (int i = 1; i <= 40 && second < 0; i++) begin
      @(negedge clk);
      if (resp_o[0]) begin
        if (first < 0) first = i; else second = i;
      end
    end
    rd_i[0] = 1'b0;
    check("held_first_resp", 256'(first), 256'(4));
    check("held_spacing", 256'(second - first), 256'(6));
    @(negedge clk);
    @(negedge clk);

    // Reset two cycles into a write aborts it.
    wr_i[0] = 1'b1; addr_i[0] = 32'h20; wdata_i[0] = {8{32'h7777_7777}};
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    wr_i[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_o[0]) nresp++;
    end
    check("reset_abort_noresp", 256'(nresp), '0);
    txn(0, 1'b1, 1'b0, 32'h20, '0, lat, rd, e);
    check("reset_abort_read20", rd, '0);

    // Minimum latency instance.
    txn(1, 1'b0, 1'b1, 32'h20, {8{32'h3333_3333}}, lat, rd, e);
    check("l1_write_latency", 256'(lat), 256'(1));
    txn(1, 1'b1, 1'b0, 32'h20, '0, lat, rd, e);
    check("l1_read20", rd, {8{32'h3333_3333}});
    wr_i[1] = 1'b1; addr_i[1] = 32'h40; wdata_i[1] = {8{32'h9999_9999}};
    @(negedge clk);
    #2 rst = 1'b1;
    wr_i[1] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    txn(1, 1'b1, 1'b0, 32'h40, '0, lat, rd, e);
    check("l1_reset_abort_read40", rd, '0);
    txn(1, 1'b1, 1'b0, 32'h20, '0, lat, rd, e);
    check("l1_reset_cleared20", rd, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
